// File: rtl/six_state_seq_checker_if.sv
// Bus bundle for the six-state sequence checker: sample strobe and code in,
// decoded phase, lock and error status out.
// With SEQ_CHK_STICKY_EN defined, the bundle also carries err_clr and err_sticky.
interface six_state_seq_checker_if #(
  parameter int CYC_W = 8,
  parameter int ERR_W = 4
);
  logic             sample_en;
  logic [2:0]       count_in;
  logic [2:0]       phase_idx;
  logic [5:0]       phase_onehot;
  logic             locked;
  logic             err_illegal;
  logic             err_order;
  logic [CYC_W-1:0] cycle_cnt;
  logic [ERR_W-1:0] err_cnt;
`ifdef SEQ_CHK_STICKY_EN
  logic             err_clr;
  logic             err_sticky;

  modport master (output sample_en, count_in, err_clr,
                  input  phase_idx, phase_onehot, locked, err_illegal,
                         err_order, cycle_cnt, err_cnt, err_sticky);
  modport slave  (input  sample_en, count_in, err_clr,
                  output phase_idx, phase_onehot, locked, err_illegal,
                         err_order, cycle_cnt, err_cnt, err_sticky);
`else
  modport master (output sample_en, count_in,
                  input  phase_idx, phase_onehot, locked, err_illegal,
                         err_order, cycle_cnt, err_cnt);
  modport slave  (input  sample_en, count_in,
                  output phase_idx, phase_onehot, locked, err_illegal,
                         err_order, cycle_cnt, err_cnt);
`endif
endinterface

// File: rtl/six_state_seq_checker.sv
// Monitor for the 3-bit six-state sequence 000,001,011,111,110,100.
// Decodes each sample, flags illegal codes and out-of-order steps, and locks
// after LOCK_N consecutive correct steps.
// Optional macro SEQ_CHK_STICKY_EN adds a sticky error flag with a clear input.
//
// state  | meaning
// IDLE   | no valid reference code yet (after reset or an illegal code)
// ACQ    | reference held, counting consecutive correct steps
// LOCK   | LOCK_N correct steps seen, sequence being tracked
module six_state_seq_checker #(
  parameter int LOCK_N = 4,
  parameter int CYC_W  = 8,
  parameter int ERR_W  = 4
) (
  input logic                    clk,
  input logic                    rstb,
  six_state_seq_checker_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} state_t;

  localparam logic [CYC_W-1:0] CYC_ONE = 1;
  localparam logic [ERR_W-1:0] ERR_ONE = 1;
  localparam logic [3:0]       LOCK_TC = 4'(LOCK_N);

  state_t           state, state_n;
  logic [2:0]       prev_code, prev_n, succ_code, dec_idx;
  logic [2:0]       phase_idx, pidx_n;
  logic [5:0]       phase_onehot, poh_n;
  logic [3:0]       good_cnt, good_n, good_inc;
  logic             locked, legal, succ_ok, wrap_step;
  logic             err_illegal, err_order, ill_n, ord_n;
  logic [CYC_W-1:0] cycle_cnt, cyc_n;
  logic [ERR_W-1:0] err_cnt, errc_n;

  // Decode the sampled code and the expected successor of the previous code.
  always_comb begin
    legal   = 1'b1;
    dec_idx = 3'b111;
    case (bus.count_in)
      3'b000:  dec_idx = 3'd0;
      3'b001:  dec_idx = 3'd1;
      3'b011:  dec_idx = 3'd2;
      3'b111:  dec_idx = 3'd3;
      3'b110:  dec_idx = 3'd4;
      3'b100:  dec_idx = 3'd5;
      default: legal   = 1'b0;
    endcase
    case (prev_code)
      3'b000:  succ_code = 3'b001;
      3'b001:  succ_code = 3'b011;
      3'b011:  succ_code = 3'b111;
      3'b111:  succ_code = 3'b110;
      3'b110:  succ_code = 3'b100;
      default: succ_code = 3'b000;
    endcase
    succ_ok   = legal && (bus.count_in == succ_code);
    wrap_step = (prev_code == 3'b100) && (bus.count_in == 3'b000);
    good_inc  = good_cnt + 4'd1;
  end

  // Next-state, counters and error pulses; everything holds without sample_en.
  always_comb begin
    state_n = state;
    prev_n  = prev_code;
    good_n  = good_cnt;
    pidx_n  = phase_idx;
    poh_n   = phase_onehot;
    ill_n   = 1'b0;
    ord_n   = 1'b0;
    cyc_n   = cycle_cnt;
    errc_n  = err_cnt;
    if (bus.sample_en) begin
      pidx_n = dec_idx;
      poh_n  = legal ? (6'b000001 << dec_idx) : 6'b000000;
      if (legal) prev_n = bus.count_in;
      case (state)
        S_IDLE: begin
          if (legal) begin
            state_n = S_ACQ;
            good_n  = 4'd0;
          end else begin
            ill_n = 1'b1;
          end
        end
        S_ACQ: begin
          if (!legal) begin
            state_n = S_IDLE;
            ill_n   = 1'b1;
          end else if (succ_ok) begin
            if (good_inc == LOCK_TC) begin
              state_n = S_LOCK;
              good_n  = 4'd0;
              if (wrap_step) cyc_n = cycle_cnt + CYC_ONE;
            end else begin
              good_n = good_inc;
            end
          end else begin
            good_n = 4'd0;
            ord_n  = 1'b1;
          end
        end
        default: begin
          if (!legal) begin
            state_n = S_IDLE;
            ill_n   = 1'b1;
          end else if (succ_ok) begin
            if (wrap_step) cyc_n = cycle_cnt + CYC_ONE;
          end else begin
            state_n = S_ACQ;
            good_n  = 4'd0;
            ord_n   = 1'b1;
          end
        end
      endcase
      if ((ill_n || ord_n) && (err_cnt != {ERR_W{1'b1}})) errc_n = err_cnt + ERR_ONE;
    end
  end

  // State and output registers; reset wins over sample_en.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state        <= S_IDLE;
      prev_code    <= 3'b000;
      good_cnt     <= 4'd0;
      phase_idx    <= 3'b111;
      phase_onehot <= 6'b000000;
      locked       <= 1'b0;
      err_illegal  <= 1'b0;
      err_order    <= 1'b0;
      cycle_cnt    <= '0;
      err_cnt      <= '0;
    end else begin
      state        <= state_n;
      prev_code    <= prev_n;
      good_cnt     <= good_n;
      phase_idx    <= pidx_n;
      phase_onehot <= poh_n;
      locked       <= (state_n == S_LOCK);
      err_illegal  <= ill_n;
      err_order    <= ord_n;
      cycle_cnt    <= cyc_n;
      err_cnt      <= errc_n;
    end
  end

`ifdef SEQ_CHK_STICKY_EN
  logic err_sticky;

  // Sticky error flag: any error pulse sets it and wins over a same-cycle clear.
  // The clear is a software action, so it works whether or not sample_en is high.
  always_ff @(posedge clk) begin
    if (rstb)                err_sticky <= 1'b0;
    else if (ill_n || ord_n) err_sticky <= 1'b1;
    else if (bus.err_clr)    err_sticky <= 1'b0;
  end

  assign bus.err_sticky = err_sticky;
`endif

  assign bus.phase_idx    = phase_idx;
  assign bus.phase_onehot = phase_onehot;
  assign bus.locked       = locked;
  assign bus.err_illegal  = err_illegal;
  assign bus.err_order    = err_order;
  assign bus.cycle_cnt    = cycle_cnt;
  assign bus.err_cnt      = err_cnt;
endmodule

// File: tb/tb_six_state_seq_checker.sv
// Directed bench for six_state_seq_checker; a second instance with CYC_W=2
// shares the stimulus to exercise cycle_cnt wrap.
module tb_six_state_seq_checker;
  logic       clk = 1'b0;
  logic       rstb = 1'b1;
  logic       sample_en = 1'b0;
  logic [2:0] count_in = 3'b000;
  logic       err_clr = 1'b0;
  int         total = 0;
  int         bad = 0;

  six_state_seq_checker_if #(.CYC_W(8), .ERR_W(4)) bus1 ();
  six_state_seq_checker_if #(.CYC_W(2), .ERR_W(4)) bus2 ();

  assign bus1.sample_en = sample_en;
  assign bus1.count_in  = count_in;
  assign bus2.sample_en = sample_en;
  assign bus2.count_in  = count_in;
`ifdef SEQ_CHK_STICKY_EN
  assign bus1.err_clr   = err_clr;
  assign bus2.err_clr   = err_clr;
`endif

  six_state_seq_checker #(.LOCK_N(4), .CYC_W(8), .ERR_W(4)) dut (.clk(clk), .rstb(rstb), .bus(bus1));
  six_state_seq_checker #(.LOCK_N(4), .CYC_W(2), .ERR_W(4)) dut2 (.clk(clk), .rstb(rstb), .bus(bus2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic en, input logic [2:0] code);
    @(negedge clk);
    sample_en = en;
    count_in  = code;
    @(posedge clk);
    #1;
  endtask

  // Checks decoded phase, lock and both error pulses after one sample.
  task automatic expect_out(input string tag, input logic [2:0] idx, input logic lk,
                            input logic ill, input logic ord);
    check({tag, ".idx"}, bus1.phase_idx, idx);
    check({tag, ".lock"}, bus1.locked, lk);
    check({tag, ".ill"}, bus1.err_illegal, ill);
    check({tag, ".ord"}, bus1.err_order, ord);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b1;
    sample_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstb = 1'b0;
  endtask

  task automatic full_seq();
    step(1, 3'b001); step(1, 3'b011); step(1, 3'b111);
    step(1, 3'b110); step(1, 3'b100); step(1, 3'b000);
  endtask

  logic [2:0] clean_code [7] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
  logic       clean_lock [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    // reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    check("rst.idx", bus1.phase_idx, 3'b111);
    check("rst.onehot", bus1.phase_onehot, 6'b0);
    check("rst.lock", bus1.locked, 1'b0);
    check("rst.cyc", bus1.cycle_cnt, 8'd0);
    check("rst.errc", bus1.err_cnt, 4'd0);
    @(negedge clk);
    rstb = 1'b0;

    // clean run: lock after the 4th correct step (110)
    for (int i = 0; i < 7; i++) begin
      step(1, clean_code[i]);
      expect_out($sformatf("clean%0d", i), 3'(i % 6), clean_lock[i], 1'b0, 1'b0);
    end
    check("clean.onehot", bus1.phase_onehot, 6'b000001);
    check("clean.cyc", bus1.cycle_cnt, 8'd1);
    check("clean.errc", bus1.err_cnt, 4'd0);

    // order error in LOCK, then relock after 4 more correct steps
    step(1, 3'b001); step(1, 3'b011);
    expect_out("pre_ord", 3'd2, 1'b1, 1'b0, 1'b0);
    step(1, 3'b110);
    expect_out("ord", 3'd4, 1'b0, 1'b0, 1'b1);
    check("ord.errc", bus1.err_cnt, 4'd1);
    step(1, 3'b100); step(1, 3'b000); step(1, 3'b001);
    expect_out("relock3", 3'd1, 1'b0, 1'b0, 1'b0);
    check("relock3.cyc", bus1.cycle_cnt, 8'd1);
    step(1, 3'b011);
    expect_out("relock4", 3'd2, 1'b1, 1'b0, 1'b0);

    // cycle counting; the narrow instance wraps at 4
    step(1, 3'b111); step(1, 3'b110); step(1, 3'b100); step(1, 3'b000);
    full_seq(); full_seq();
    check("cyc4", bus1.cycle_cnt, 8'd4);
    check("cyc4.w2", bus2.cycle_cnt, 2'd0);
    full_seq();
    check("cyc5", bus1.cycle_cnt, 8'd5);
    check("cyc5.w2", bus2.cycle_cnt, 2'd1);
    check("cyc5.errc", bus1.err_cnt, 4'd1);

    // sample_en gap between 011 and 111, with junk on count_in
    step(1, 3'b001); step(1, 3'b011);
    for (int i = 0; i < 3; i++) begin
      step(0, 3'b010);
      expect_out($sformatf("gap%0d", i), 3'd2, 1'b1, 1'b0, 1'b0);
    end
    step(1, 3'b111);
    expect_out("gap_end", 3'd3, 1'b1, 1'b0, 1'b0);
    check("gap.errc", bus1.err_cnt, 4'd1);

    // 20 illegal codes saturate err_cnt
    step(1, 3'b010);
    expect_out("ill1", 3'b111, 1'b0, 1'b1, 1'b0);
    check("ill1.errc", bus1.err_cnt, 4'd2);
    for (int i = 1; i < 20; i++) step(1, (i % 2) ? 3'b101 : 3'b010);
    check("sat.errc", bus1.err_cnt, 4'd15);
    check("sat.ill", bus1.err_illegal, 1'b1);
    check("sat.onehot", bus1.phase_onehot, 6'b0);

    // illegal start after reset
    do_reset();
    step(1, 3'b101);
    expect_out("istart", 3'b111, 1'b0, 1'b1, 1'b0);
    check("istart.onehot", bus1.phase_onehot, 6'b0);
    check("istart.errc", bus1.err_cnt, 4'd1);
    step(1, 3'b000);
    expect_out("istart0", 3'd0, 1'b0, 1'b0, 1'b0);
    step(1, 3'b001);
    expect_out("istart1", 3'd1, 1'b0, 1'b0, 1'b0);
    check("istart1.errc", bus1.err_cnt, 4'd1);

    // lock entered on a 100->000 step counts a cycle
    do_reset();
    step(1, 3'b011); step(1, 3'b111); step(1, 3'b110); step(1, 3'b100);
    expect_out("acqwrap3", 3'd5, 1'b0, 1'b0, 1'b0);
    step(1, 3'b000);
    expect_out("acqwrap4", 3'd0, 1'b1, 1'b0, 1'b0);
    check("acqwrap.cyc", bus1.cycle_cnt, 8'd1);

    // reset mid-lock beats a simultaneous sample
    @(negedge clk);
    rstb = 1'b1;
    sample_en = 1'b1;
    count_in = 3'b001;
    @(posedge clk);
    #1;
    expect_out("midrst", 3'b111, 1'b0, 1'b0, 1'b0);
    check("midrst.onehot", bus1.phase_onehot, 6'b0);
    check("midrst.cyc", bus1.cycle_cnt, 8'd0);
    @(negedge clk);
    rstb = 1'b0;
    sample_en = 1'b0;

`ifdef SEQ_CHK_STICKY_EN
    @(posedge clk);
    #1;
    check("stk.rst", bus1.err_sticky, 1'b0);
    step(1, 3'b010);
    check("stk.set", bus1.err_sticky, 1'b1);
    err_clr = 1'b1;
    step(1, 3'b000);
    check("stk.clr", bus1.err_sticky, 1'b0);
    step(1, 3'b010);
    check("stk.setwins", bus1.err_sticky, 1'b1);
    @(negedge clk);
    err_clr = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/six_state_seq_checker.md
Name: six_state_seq_checker

Overview:
- Downstream monitor for the 3-bit six-state sequence counter (legal codes, in order: 000, 001, 011, 111, 110, 100, then back to 000).
- Samples the counter output and decodes it to a phase index and a one-hot phase.
- Flags illegal codes and out-of-order steps, and declares lock after consecutive correct steps.
- Counts completed sequence cycles and errors for status/debug logic.

Parameters:
- LOCK_N, 4, consecutive correct transitions needed to enter LOCK; legal range 1..15.
- CYC_W, 8, width of cycle_cnt; wraps.
- ERR_W, 4, width of err_cnt; saturates.

Ports:
- clk  input  1  rising-edge clock.
- rstb  input  1  synchronous, active-high reset (1 = reset); sampled on clk rising edge.
- sample_en  input  1  1 = sample count_in this cycle; 0 = hold all state, no pulses.
- count_in  input  3  sequence counter value.
- phase_idx  output  3  decoded phase 0..5 (000→0, 001→1, 011→2, 111→3, 110→4, 100→5); 3'b111 for an illegal code.
- phase_onehot  output  6  bit[phase_idx] set; all-zero for an illegal code.
- locked  output  1  1 while FSM is in LOCK.
- err_illegal  output  1  one-cycle pulse: illegal code (010 or 101) sampled.
- err_order  output  1  one-cycle pulse: legal code sampled that is not the successor of the previous code.
- cycle_cnt  output  CYC_W  count of 100→000 steps taken while in LOCK.
- err_cnt  output  ERR_W  saturating count of err_illegal and err_order pulses.

Behaviour:
- All outputs are registered. Response appears 1 clk after the sampling edge (sample_en=1).
- Reset (rstb=1 at a clk edge) has priority over sample_en. It sets:
  - FSM=IDLE, prev_code=000, good_cnt=0.
  - phase_idx=3'b111, phase_onehot=0.
  - locked=0, err_illegal=0, err_order=0.
  - cycle_cnt=0, err_cnt=0.
- Reset asserted mid-operation discards lock and counters on that edge.
- Successor function: succ(000)=001, succ(001)=011, succ(011)=111, succ(111)=110, succ(110)=100, succ(100)=000.
- A repeated code counts as an order error.
- FSM (evaluated only when sample_en=1):
  - IDLE:
    - Legal code → ACQ; prev_code=code; good_cnt=0.
    - Illegal code → stay IDLE; pulse err_illegal.
  - ACQ:
    - code==succ(prev_code) → good_cnt+1. If good_cnt+1==LOCK_N → LOCK, good_cnt=0.
    - Legal but wrong code → stay ACQ; good_cnt=0; pulse err_order.
    - Illegal code → IDLE; pulse err_illegal.
  - LOCK:
    - code==succ(prev_code) → stay LOCK.
    - Legal but wrong code → ACQ; good_cnt=0; pulse err_order.
    - Illegal code → IDLE; pulse err_illegal.
  - prev_code updates on every legal sample. Illegal samples leave prev_code unchanged.
- locked is high the cycle after the transition into LOCK, and low the cycle after leaving LOCK.
- cycle_cnt increments when a correct 100→000 step is sampled in LOCK, or on the step that enters LOCK if that step is 100→000. It wraps at 2^CYC_W.
- err_cnt increments by 1 per error pulse and saturates at all-ones. err_illegal and err_order are mutually exclusive.
- phase_idx and phase_onehot are updated on every sample regardless of FSM state.
- sample_en=0:
  - All registers hold.
  - err_illegal and err_order are 0.
  - Gaps do not break the sequence; the next sample is compared against prev_code.

Optional Feature:
- Macro: SEQ_CHK_STICKY_EN.
- Defined:
  - Adds input err_clr (1 bit) and output err_sticky (1 bit).
  - err_sticky sets on any error pulse.
  - err_sticky clears on err_clr=1 unless an error pulse occurs in the same cycle; set wins.
  - Reset value 0.
- Undefined: neither port exists; no other behaviour changes.

Test Plan:
- Reset then clean run: hold rstb=1 for 2 clk. Release. Drive 000,001,011,111,110,100,000 with sample_en=1.
  → phase_idx 0,1,2,3,4,5,0 (each 1 clk late); locked=1 after the 4th correct step; no error pulses; err_cnt=0.
- Illegal start: first sample 101, then 000,001 → err_illegal pulses once; FSM stays IDLE, then ACQ; phase_idx=7, onehot=0 for that sample; err_cnt=1.
- Order error in LOCK: once locked, drive 011 then 110 → err_order pulse; locked drops the next cycle; relock after 4 further correct steps.
- Cycle count: locked; run 3 full sequences → cycle_cnt=3. With CYC_W=2, run 5 sequences → cycle_cnt=1 (wrap).
- sample_en gaps and saturation: insert sample_en=0 for 3 cycles between 011 and 111 → no error, lock held. Then inject 20 illegal codes (ERR_W=4) → err_cnt=15.
- Reset mid-lock plus sticky (SEQ_CHK_STICKY_EN):
  - Assert rstb in LOCK → all outputs return to reset values next cycle.
  - Error then err_clr → err_sticky 1 then 0.
  - Error coincident with err_clr → err_sticky stays 1.
